// File: rtl/fpu_seq_pkg.sv
// Shared types for the FPU command sequencer: opcodes, FSM states and the
// response record carried through the response FIFO.
package fpu_seq_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } fpu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WAIT   = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  tag;
    logic        sp_dp;
    logic        overflow;
    logic        underflow;
    logic        timeout;
  } fpu_rsp_t;

  // Single-precision results are zero-extended into the 64-bit response word.
  function automatic logic [63:0] select_result(input logic        sp_dp,
                                                input logic [31:0] res_sp,
                                                input logic [63:0] res_dp);
    select_result = sp_dp ? res_dp : {32'h0000_0000, res_sp};
  endfunction

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Two-entry response FIFO; the head entry is presented directly from storage
// flops so every rsp_* output is register-driven.
module fpu_rsp_fifo
  import fpu_seq_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  fpu_rsp_t push_data,
  input  logic     pop,
  output fpu_rsp_t head,
  output logic     empty,
  output logic     full
);

  fpu_rsp_t   mem_q [2];
  fpu_rsp_t   mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_pop_s;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    do_pop_s = pop && (count_q != 2'd0);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, do_pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);

  fpu_rsp_fifo_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .full  (full)
  );

endmodule

// File: rtl/fpu_rsp_fifo_chk.sv
// Protocol checker for the response FIFO: the sequencer's accept rule must
// never let a push land on a full buffer.
module fpu_rsp_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic full
);

  // A push into a full FIFO would silently overwrite an undelivered response.
  no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// Sequences one FPU operation at a time: launches operands, masks stale ready
// for a settle window, waits (bounded) for the result and queues a response.
module fpu_cmd_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_sp_dp,
  input  logic [1:0]  cmd_op,
  input  logic [63:0] cmd_a,
  input  logic [63:0] cmd_b,
  input  logic [3:0]  cmd_tag,
  output logic        fpu_sp_dp,
  output logic [1:0]  fpu_opCode,
  output logic [31:0] fpu_a_sp,
  output logic [31:0] fpu_b_sp,
  output logic [63:0] fpu_a_dp,
  output logic [63:0] fpu_b_dp,
  input  logic [31:0] fpu_result_sp,
  input  logic [63:0] fpu_result_dp,
  input  logic        fpu_overflow,
  input  logic        fpu_underflow,
  input  logic        fpu_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [3:0]  rsp_tag,
  output logic        rsp_sp_dp,
  output logic        rsp_overflow,
  output logic        rsp_underflow,
  output logic        rsp_timeout,
  output logic [15:0] ops_done
);

  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  seq_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] ops_done_q, ops_done_d;
  logic        sp_dp_q, sp_dp_d;
  fpu_op_e     op_q, op_d;
  logic [31:0] a_sp_q, a_sp_d, b_sp_q, b_sp_d;
  logic [63:0] a_dp_q, a_dp_d, b_dp_q, b_dp_d;
  logic [3:0]  tag_q, tag_d;
  logic        push_s, pop_s, fifo_empty_s, fifo_full_s;
  fpu_rsp_t    push_rsp_s, head_s;

  // rst_n gating keeps cmd_ready low throughout reset while IDLE is the reset state.
  assign cmd_ready = rst_n && (state_q == IDLE) && !fifo_full_s;
  assign pop_s     = rsp_valid && rsp_ready;

  // FSM next-state, operand launch and response formation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sp_dp_d    = sp_dp_q;
    op_d       = op_q;
    a_sp_d     = a_sp_q;
    b_sp_d     = b_sp_q;
    a_dp_d     = a_dp_q;
    b_dp_d     = b_dp_q;
    tag_d      = tag_q;
    push_s     = 1'b0;
    push_rsp_s = '0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          sp_dp_d = cmd_sp_dp;
          op_d    = fpu_op_e'(cmd_op);
          a_sp_d  = cmd_sp_dp ? 32'h0000_0000 : cmd_a[31:0];
          b_sp_d  = cmd_sp_dp ? 32'h0000_0000 : cmd_b[31:0];
          a_dp_d  = cmd_sp_dp ? cmd_a : 64'h0;
          b_dp_d  = cmd_sp_dp ? cmd_b : 64'h0;
          tag_d   = cmd_tag;
          cnt_d   = 16'd0;
          state_d = (SETTLE_CYCLES == 0) ? WAIT : SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 16'd0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT: begin
        push_rsp_s.tag   = tag_q;
        push_rsp_s.sp_dp = sp_dp_q;
        if (fpu_ready) begin
          push_s               = 1'b1;
          push_rsp_s.data      = select_result(sp_dp_q, fpu_result_sp, fpu_result_dp);
          push_rsp_s.overflow  = fpu_overflow;
          push_rsp_s.underflow = fpu_underflow;
          state_d              = IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          push_s             = 1'b1;
          push_rsp_s.timeout = 1'b1;
          state_d            = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
    if (push_s) begin
      ops_done_d = ops_done_q + 16'd1;
    end else begin
      ops_done_d = ops_done_q;
    end
  end

  // FSM and launch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      ops_done_q <= 16'd0;
      sp_dp_q    <= 1'b0;
      op_q       <= ADD;
      a_sp_q     <= 32'h0000_0000;
      b_sp_q     <= 32'h0000_0000;
      a_dp_q     <= 64'h0;
      b_dp_q     <= 64'h0;
      tag_q      <= 4'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ops_done_q <= ops_done_d;
      sp_dp_q    <= sp_dp_d;
      op_q       <= op_d;
      a_sp_q     <= a_sp_d;
      b_sp_q     <= b_sp_d;
      a_dp_q     <= a_dp_d;
      b_dp_q     <= b_dp_d;
      tag_q      <= tag_d;
    end
  end

  fpu_rsp_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_rsp_s),
    .pop       (pop_s),
    .head      (head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  assign fpu_sp_dp     = sp_dp_q;
  assign fpu_opCode    = op_q;
  assign fpu_a_sp      = a_sp_q;
  assign fpu_b_sp      = b_sp_q;
  assign fpu_a_dp      = a_dp_q;
  assign fpu_b_dp      = b_dp_q;
  assign rsp_valid     = !fifo_empty_s;
  assign rsp_data      = head_s.data;
  assign rsp_tag       = head_s.tag;
  assign rsp_sp_dp     = head_s.sp_dp;
  assign rsp_overflow  = head_s.overflow;
  assign rsp_underflow = head_s.underflow;
  assign rsp_timeout   = head_s.timeout;
  assign ops_done      = ops_done_q;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Directed bench for fpu_cmd_sequencer with default SETTLE_CYCLES=2,
// TIMEOUT_CYCLES=64; the FPU is modelled by driving ready/result by hand.
module tb_fpu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_sp_dp;
  logic [1:0]  cmd_op;
  logic [63:0] cmd_a, cmd_b;
  logic [3:0]  cmd_tag;
  logic        fpu_sp_dp;
  logic [1:0]  fpu_opCode;
  logic [31:0] fpu_a_sp, fpu_b_sp;
  logic [63:0] fpu_a_dp, fpu_b_dp;
  logic [31:0] fpu_result_sp;
  logic [63:0] fpu_result_dp;
  logic        fpu_overflow, fpu_underflow, fpu_ready;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_sp_dp, rsp_overflow, rsp_underflow, rsp_timeout;
  logic [15:0] ops_done;

  int checks   = 0;
  int failures = 0;
  int exp_ops  = 0;

  always #5 clk = ~clk;

  fpu_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sp_dp(cmd_sp_dp),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .fpu_sp_dp(fpu_sp_dp), .fpu_opCode(fpu_opCode),
    .fpu_a_sp(fpu_a_sp), .fpu_b_sp(fpu_b_sp), .fpu_a_dp(fpu_a_dp), .fpu_b_dp(fpu_b_dp),
    .fpu_result_sp(fpu_result_sp), .fpu_result_dp(fpu_result_dp),
    .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow), .fpu_ready(fpu_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_sp_dp(rsp_sp_dp), .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
    .rsp_timeout(rsp_timeout), .ops_done(ops_done)
  );

  // Offer a command from a negedge; returns at the negedge after the accepting edge.
  task automatic send_cmd(input logic sp, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] tag);
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_sp_dp = sp; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL accept_tag%0d: cmd_ready never high within 20 cycles", tag); end
    else @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pop_one();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready: got %b exp 0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
    checks++; if (ops_done !== 16'h0) begin failures++; $display("FAIL rst_ops_done: got %h exp 0", ops_done); end
    checks++; if (fpu_a_dp !== 64'h0 || rsp_data !== 64'h0) begin
      failures++; $display("FAIL rst_outputs: a_dp %h rsp_data %h exp 0", fpu_a_dp, rsp_data); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rel_cmd_ready: got %b exp 1", cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_sp_add();
    fpu_ready = 1'b0; fpu_result_dp = 64'hDEAD_BEEF_DEAD_BEEF;
    send_cmd(1'b0, 2'd0, 64'h0000_0000_3F80_0000, 64'h0000_0000_4000_0000, 4'h5);
    checks++; if (fpu_a_sp !== 32'h3F80_0000 || fpu_b_sp !== 32'h4000_0000) begin
      failures++; $display("FAIL sp_operands: got %h/%h exp 3f800000/40000000", fpu_a_sp, fpu_b_sp); end
    checks++; if (fpu_a_dp !== 64'h0 || fpu_sp_dp !== 1'b0 || fpu_opCode !== 2'd0) begin
      failures++; $display("FAIL sp_ctrl: a_dp %h sp_dp %b op %0d exp 0/0/0", fpu_a_dp, fpu_sp_dp, fpu_opCode); end
    @(negedge clk); @(negedge clk);
    fpu_result_sp = 32'h4040_0000; fpu_overflow = 1'b0; fpu_underflow = 1'b0; fpu_ready = 1'b1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL sp_early: rsp_valid %b exp 0", rsp_valid); end
    @(negedge clk);
    fpu_ready = 1'b0;
    exp_ops++;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h0000_0000_4040_0000) begin
      failures++; $display("FAIL sp_add_data: valid %b data %h exp 1/0000000040400000", rsp_valid, rsp_data); end
    checks++; if (rsp_tag !== 4'h5 || rsp_overflow !== 1'b0 || rsp_underflow !== 1'b0 || rsp_timeout !== 1'b0) begin
      failures++; $display("FAIL sp_add_meta: tag %h ov %b un %b to %b exp 5/0/0/0", rsp_tag, rsp_overflow, rsp_underflow, rsp_timeout); end
    checks++; if (ops_done !== 16'(exp_ops)) begin failures++; $display("FAIL sp_ops_done: got %0d exp %0d", ops_done, exp_ops); end
    pop_one();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL sp_pop: rsp_valid %b exp 0", rsp_valid); end
  endtask

  task automatic test_dp_mul();
    fpu_ready = 1'b0; fpu_result_sp = 32'h1234_5678;
    send_cmd(1'b1, 2'd2, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 4'hA);
    for (int i = 0; i < 3; i++) begin
      checks++; if (fpu_a_sp !== 32'h0 || fpu_b_sp !== 32'h0) begin
        failures++; $display("FAIL dp_sp_zero: a_sp %h b_sp %h exp 0", fpu_a_sp, fpu_b_sp); end
      if (i == 1) begin
        fpu_result_dp = 64'h4018_0000_0000_0000; fpu_overflow = 1'b1; fpu_underflow = 1'b0; fpu_ready = 1'b1;
      end
      @(negedge clk);
    end
    fpu_ready = 1'b0; fpu_overflow = 1'b0;
    exp_ops++;
    checks++; if (fpu_a_dp !== 64'h4000_0000_0000_0000 || fpu_b_dp !== 64'h4008_0000_0000_0000 || fpu_opCode !== 2'd2) begin
      failures++; $display("FAIL dp_operands: %h %h op %0d", fpu_a_dp, fpu_b_dp, fpu_opCode); end
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h4018_0000_0000_0000 || rsp_sp_dp !== 1'b1) begin
      failures++; $display("FAIL dp_mul_data: valid %b data %h sp_dp %b exp 1/4018000000000000/1", rsp_valid, rsp_data, rsp_sp_dp); end
    checks++; if (rsp_overflow !== 1'b1 || rsp_tag !== 4'hA) begin
      failures++; $display("FAIL dp_mul_meta: ov %b tag %h exp 1/a", rsp_overflow, rsp_tag); end
    pop_one();
  endtask

  task automatic test_stale_ready();
    fpu_result_sp = 32'hAAAA_AAAA; fpu_ready = 1'b1;
    send_cmd(1'b0, 2'd1, 64'h0000_0000_4000_0000, 64'h0000_0000_3F80_0000, 4'h9);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL stale_n0: rsp_valid %b exp 0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL stale_n1: rsp_valid %b exp 0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL stale_n2: rsp_valid %b exp 0", rsp_valid); end
    fpu_result_sp = 32'h3F80_0000;
    @(negedge clk);
    fpu_ready = 1'b0;
    exp_ops++;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h0000_0000_3F80_0000 || rsp_tag !== 4'h9) begin
      failures++; $display("FAIL stale_capture: valid %b data %h tag %h exp 1/000000003f800000/9", rsp_valid, rsp_data, rsp_tag); end
    pop_one();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0; fpu_ready = 1'b1;
    fpu_result_sp = 32'h0000_0001;
    send_cmd(1'b0, 2'd0, 64'h11, 64'h11, 4'h1);
    repeat (3) @(negedge clk);
    exp_ops++;
    checks++; if (ops_done !== 16'(exp_ops)) begin failures++; $display("FAIL b2b_op1: ops_done %0d exp %0d", ops_done, exp_ops); end
    fpu_result_sp = 32'h0000_0002;
    send_cmd(1'b0, 2'd0, 64'h22, 64'h22, 4'h2);
    repeat (3) @(negedge clk);
    exp_ops++;
    checks++; if (ops_done !== 16'(exp_ops)) begin failures++; $display("FAIL b2b_op2: ops_done %0d exp %0d", ops_done, exp_ops); end
    fpu_result_sp = 32'h0000_0003;
    cmd_valid = 1'b1; cmd_sp_dp = 1'b0; cmd_op = 2'd0; cmd_a = 64'h33; cmd_b = 64'h33; cmd_tag = 4'h3;
    for (int i = 0; i < 4; i++) begin
      checks++; if (cmd_ready !== 1'b0 || fpu_a_sp !== 32'h22) begin
        failures++; $display("FAIL b2b_full: cmd_ready %b a_sp %h exp 0/22", cmd_ready, fpu_a_sp); end
      @(negedge clk);
    end
    checks++; if (rsp_tag !== 4'h1 || rsp_data !== 64'h1) begin
      failures++; $display("FAIL b2b_head1: tag %h data %h exp 1/1", rsp_tag, rsp_data); end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'h2 || rsp_data !== 64'h2) begin
      failures++; $display("FAIL b2b_head2: valid %b tag %h data %h exp 1/2/2", rsp_valid, rsp_tag, rsp_data); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_reopen: cmd_ready %b exp 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || fpu_a_sp !== 32'h33) begin
      failures++; $display("FAIL b2b_drain: rsp_valid %b a_sp %h exp 0/33", rsp_valid, fpu_a_sp); end
    repeat (3) @(negedge clk);
    fpu_ready = 1'b0;
    exp_ops++;
    checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'h3 || rsp_data !== 64'h3) begin
      failures++; $display("FAIL b2b_head3: valid %b tag %h data %h exp 1/3/3", rsp_valid, rsp_tag, rsp_data); end
    pop_one();
  endtask

  task automatic test_timeout();
    fpu_ready = 1'b0; fpu_result_dp = 64'hFFFF_FFFF_FFFF_FFFF; fpu_overflow = 1'b1; fpu_underflow = 1'b1;
    send_cmd(1'b1, 2'd3, 64'h4000_0000_0000_0000, 64'h0, 4'h7);
    repeat (65) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL to_early: rsp_valid %b exp 0", rsp_valid); end
    @(negedge clk);
    exp_ops++;
    checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_data !== 64'h0) begin
      failures++; $display("FAIL to_rsp: valid %b timeout %b data %h exp 1/1/0", rsp_valid, rsp_timeout, rsp_data); end
    checks++; if (rsp_overflow !== 1'b0 || rsp_underflow !== 1'b0 || rsp_tag !== 4'h7) begin
      failures++; $display("FAIL to_meta: ov %b un %b tag %h exp 0/0/7", rsp_overflow, rsp_underflow, rsp_tag); end
    checks++; if (ops_done !== 16'(exp_ops)) begin failures++; $display("FAIL to_ops_done: got %0d exp %0d", ops_done, exp_ops); end
    fpu_overflow = 1'b0; fpu_underflow = 1'b0;
    pop_one();
  endtask

  task automatic test_reset_mid_op();
    fpu_ready = 1'b0;
    send_cmd(1'b0, 2'd0, 64'h1, 64'h2, 4'hC);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0 || ops_done !== 16'h0) begin
      failures++; $display("FAIL mid_rst: cmd_ready %b ops_done %0d exp 0/0", cmd_ready, ops_done); end
    @(negedge clk);
    rst_n = 1'b1; fpu_ready = 1'b1; exp_ops = 0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_rel_ready: got %b exp 1", cmd_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || ops_done !== 16'h0) begin
        failures++; $display("FAIL mid_no_rsp: rsp_valid %b ops_done %0d exp 0/0", rsp_valid, ops_done); end
    end
    fpu_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_sp_dp = 1'b0; cmd_op = 2'd0; cmd_a = 64'h0; cmd_b = 64'h0;
    cmd_tag = 4'h0; fpu_result_sp = 32'h0; fpu_result_dp = 64'h0; fpu_overflow = 1'b0;
    fpu_underflow = 1'b0; fpu_ready = 1'b0; rsp_ready = 1'b0;
    test_reset();
    test_sp_add();
    test_dp_mul();
    test_stale_ready();
    test_back_to_back();
    test_timeout();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
